// File: rtl/regfile_ctx_if.sv
// Bus bundle for regfile_ctx: read/write ports, stack and context requests, state outputs.
interface regfile_ctx_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_GPR = 8,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned ADDR_W  = 12
);
    logic [SEL_W-1:0]          read_sel1;
    logic [SEL_W-1:0]          read_sel2;
    logic [SEL_W-1:0]          write_sel;
    logic                      write_en;
    logic [DATA_W-1:0]         write_data;
    logic                      sp_push;
    logic                      sp_pop;
    logic                      ctx_save;
    logic                      ctx_restore;
    logic                      flag_clr;
    logic [DATA_W-1:0]         read_data1;
    logic [DATA_W-1:0]         read_data2;
    logic [NUM_GPR*DATA_W-1:0] regs_out_flat;
    logic [ADDR_W-1:0]         sp_out;
    logic [ADDR_W-1:0]         isr_out;
    logic                      shadow_valid;
    logic                      stk_ovf;
    logic                      stk_unf;
    logic                      nest_err;

    modport master (
        output read_sel1, read_sel2, write_sel, write_en, write_data,
               sp_push, sp_pop, ctx_save, ctx_restore, flag_clr,
        input  read_data1, read_data2, regs_out_flat, sp_out, isr_out,
               shadow_valid, stk_ovf, stk_unf, nest_err
    );

    modport slave (
        input  read_sel1, read_sel2, write_sel, write_en, write_data,
               sp_push, sp_pop, ctx_save, ctx_restore, flag_clr,
        output read_data1, read_data2, regs_out_flat, sp_out, isr_out,
               shadow_valid, stk_ovf, stk_unf, nest_err
    );
endinterface

// File: rtl/regfile_ctx.sv
// Register bank with GPRs, SP, ISR, bounded hardware stack and a one-level shadow
// bank for interrupt context save/restore.
module regfile_ctx #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       NUM_GPR  = 8,
    parameter int unsigned       SEL_W    = 4,
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_TOP   = 12'hFFF,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 12'h800,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_ctx_if.slave bus
);
    localparam int unsigned SEL_SP  = NUM_GPR;
    localparam int unsigned SEL_ISR = NUM_GPR + 1;

    logic [DATA_W-1:0] gpr     [NUM_GPR];
    logic [DATA_W-1:0] gpr_nxt [NUM_GPR];
    logic [DATA_W-1:0] sh_gpr     [NUM_GPR];
    logic [DATA_W-1:0] sh_gpr_nxt [NUM_GPR];
    logic [ADDR_W-1:0] sp, sp_nxt, isr, isr_nxt, sh_isr, sh_isr_nxt;
    logic              sv, sv_nxt, ovf, ovf_nxt, unf, unf_nxt, nest, nest_nxt;

    logic [NUM_GPR-1:0] wr_gpr;
    logic               wr_sp, wr_isr, wr_any;
    logic               save_ok, restore_ok, nest_ev, push_ev, pop_ev;

    // Decode of the write target and request qualification
    always_comb begin
        for (int j = 0; j < NUM_GPR; j++) begin
            wr_gpr[j] = bus.write_en && (bus.write_sel == SEL_W'(j));
        end
        wr_sp      = bus.write_en && (bus.write_sel == SEL_W'(SEL_SP));
        wr_isr     = bus.write_en && (bus.write_sel == SEL_W'(SEL_ISR));
        wr_any     = (|wr_gpr) || wr_sp || wr_isr;
        save_ok    = bus.ctx_save && !bus.ctx_restore && !sv;
        restore_ok = bus.ctx_restore && !bus.ctx_save && sv;
        nest_ev    = (bus.ctx_save || bus.ctx_restore) && !save_ok && !restore_ok;
        // An explicit SP write overrides any stack request in the same cycle
        push_ev    = bus.sp_push && !bus.sp_pop && !wr_sp;
        pop_ev     = bus.sp_pop && !bus.sp_push && !wr_sp;
    end

    // Next-state logic
    always_comb begin
        gpr_nxt    = gpr;
        sh_gpr_nxt = sh_gpr;
        sp_nxt     = sp;
        isr_nxt    = isr;
        sh_isr_nxt = sh_isr;
        sv_nxt     = sv;
        ovf_nxt    = ovf && !bus.flag_clr;
        unf_nxt    = unf && !bus.flag_clr;
        nest_nxt   = (nest && !bus.flag_clr) || nest_ev;

        if (save_ok) begin
            sh_gpr_nxt = gpr;
            sh_isr_nxt = isr;
            sv_nxt     = 1'b1;
        end
        if (restore_ok) begin
            gpr_nxt = sh_gpr;
            isr_nxt = sh_isr;
            sv_nxt  = 1'b0;
        end

        for (int j = 0; j < NUM_GPR; j++) begin
            if (wr_gpr[j]) gpr_nxt[j] = bus.write_data;
        end
        if (wr_isr) isr_nxt = bus.write_data[ADDR_W-1:0];

        if (wr_sp) begin
            sp_nxt = bus.write_data[ADDR_W-1:0];
        end else if (push_ev) begin
            if (sp == SP_LIMIT) ovf_nxt = 1'b1;
            else                sp_nxt  = sp - ADDR_W'(1);
        end else if (pop_ev) begin
            if (sp == SP_TOP) unf_nxt = 1'b1;
            else              sp_nxt  = sp + ADDR_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_GPR; j++) begin
                gpr[j]    <= '0;
                sh_gpr[j] <= '0;
            end
            sp     <= SP_TOP;
            isr    <= '0;
            sh_isr <= '0;
            sv     <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            nest   <= 1'b0;
        end else begin
            gpr    <= gpr_nxt;
            sh_gpr <= sh_gpr_nxt;
            sp     <= sp_nxt;
            isr    <= isr_nxt;
            sh_isr <= sh_isr_nxt;
            sv     <= sv_nxt;
            ovf    <= ovf_nxt;
            unf    <= unf_nxt;
            nest   <= nest_nxt;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [SEL_W-1:0] sel);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int j = 0; j < NUM_GPR; j++) begin
            if (sel == SEL_W'(j)) r = gpr[j];
        end
        if (sel == SEL_W'(SEL_SP))  r = DATA_W'(sp);
        if (sel == SEL_W'(SEL_ISR)) r = DATA_W'(isr);
        // Bypass covers explicit writes only; push/pop never forward
        if (BYPASS && wr_any && (sel == bus.write_sel)) begin
            r = (wr_sp || wr_isr) ? DATA_W'(bus.write_data[ADDR_W-1:0]) : bus.write_data;
        end
        return r;
    endfunction

    assign bus.read_data1 = read_port(bus.read_sel1);
    assign bus.read_data2 = read_port(bus.read_sel2);

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_flat
        assign bus.regs_out_flat[g*DATA_W +: DATA_W] = gpr[g];
    end

    assign bus.sp_out       = sp;
    assign bus.isr_out      = isr;
    assign bus.shadow_valid = sv;
    assign bus.stk_ovf      = ovf;
    assign bus.stk_unf      = unf;
    assign bus.nest_err     = nest;
endmodule

// File: tb/tb_regfile_ctx.sv
// Randomised bench for regfile_ctx against a rule-level reference model, with
// directed register, bypass, stack, context and async-reset scenarios.
module tb_regfile_ctx;
    localparam int unsigned NG  = 8;
    localparam int unsigned DW  = 16;
    localparam logic [11:0] TOP = 12'hFFF;
    localparam logic [11:0] LIM = 12'h800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_ctx_if #(.DATA_W(16), .NUM_GPR(8), .SEL_W(4), .ADDR_W(12)) bus ();
    regfile_ctx_if #(.DATA_W(16), .NUM_GPR(8), .SEL_W(4), .ADDR_W(12)) bus0 ();

    regfile_ctx #(.BYPASS(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    regfile_ctx #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    assign bus0.read_sel1   = bus.read_sel1;
    assign bus0.read_sel2   = bus.read_sel2;
    assign bus0.write_sel   = bus.write_sel;
    assign bus0.write_en    = bus.write_en;
    assign bus0.write_data  = bus.write_data;
    assign bus0.sp_push     = bus.sp_push;
    assign bus0.sp_pop      = bus.sp_pop;
    assign bus0.ctx_save    = bus.ctx_save;
    assign bus0.ctx_restore = bus.ctx_restore;
    assign bus0.flag_clr    = bus.flag_clr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_gpr [NG];
    logic [15:0] m_sh  [NG];
    logic [11:0] m_sp, m_isr, m_sh_isr;
    logic        m_sv, m_ovf, m_unf, m_nest;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NG; j++) begin m_gpr[j] = '0; m_sh[j] = '0; end
        m_sp = TOP; m_isr = '0; m_sh_isr = '0;
        m_sv = 0; m_ovf = 0; m_unf = 0; m_nest = 0;
    endtask

    // Expected read value from the register map, with optional forwarding
    function automatic logic [15:0] exp_read(input int sel, input bit byp);
        int ws = int'(bus.write_sel);
        if (byp && bus.write_en && sel == ws && ws < NG + 2)
            return (ws < NG) ? bus.write_data : {4'h0, bus.write_data[11:0]};
        if (sel < NG)       return m_gpr[sel];
        if (sel == NG)      return {4'h0, m_sp};
        if (sel == NG + 1)  return {4'h0, m_isr};
        return 16'h0;
    endfunction

    task automatic model_step();
        int  ws = int'(bus.write_sel);
        bit  we = bus.write_en;
        bit  ovf_e = 0, unf_e = 0, nest_e = 0;
        if (bus.ctx_save && bus.ctx_restore) nest_e = 1;
        else if (bus.ctx_save) begin
            if (m_sv) nest_e = 1;
            else begin m_sh = m_gpr; m_sh_isr = m_isr; m_sv = 1; end
        end else if (bus.ctx_restore) begin
            if (!m_sv) nest_e = 1;
            else begin m_gpr = m_sh; m_isr = m_sh_isr; m_sv = 0; end
        end
        if (we && ws < NG)       m_gpr[ws] = bus.write_data;
        if (we && ws == NG + 1)  m_isr = bus.write_data[11:0];
        if (we && ws == NG)      m_sp = bus.write_data[11:0];
        else if (bus.sp_push && !bus.sp_pop) begin
            if (m_sp == LIM) ovf_e = 1; else m_sp = m_sp - 12'd1;
        end else if (bus.sp_pop && !bus.sp_push) begin
            if (m_sp == TOP) unf_e = 1; else m_sp = m_sp + 12'd1;
        end
        if (bus.flag_clr) begin m_ovf = 0; m_unf = 0; m_nest = 0; end
        m_ovf  = m_ovf  | ovf_e;
        m_unf  = m_unf  | unf_e;
        m_nest = m_nest | nest_e;
    endtask

    task automatic check_all();
        for (int j = 0; j < NG; j++)
            check_val($sformatf("gpr%0d", j), 32'(bus.regs_out_flat[j*DW +: DW]), 32'(m_gpr[j]));
        check_val("sp_out", 32'(bus.sp_out), 32'(m_sp));
        check_val("isr_out", 32'(bus.isr_out), 32'(m_isr));
        check_val("shadow_valid", 32'(bus.shadow_valid), 32'(m_sv));
        check_val("stk_ovf", 32'(bus.stk_ovf), 32'(m_ovf));
        check_val("stk_unf", 32'(bus.stk_unf), 32'(m_unf));
        check_val("nest_err", 32'(bus.nest_err), 32'(m_nest));
        check_val("rd1_byp", 32'(bus.read_data1), 32'(exp_read(int'(bus.read_sel1), 1'b1)));
        check_val("rd2_byp", 32'(bus.read_data2), 32'(exp_read(int'(bus.read_sel2), 1'b1)));
        check_val("rd1_nobyp", 32'(bus0.read_data1), 32'(exp_read(int'(bus.read_sel1), 1'b0)));
        check_val("rd2_nobyp", 32'(bus0.read_data2), 32'(exp_read(int'(bus.read_sel2), 1'b0)));
    endtask

    task automatic idle();
        bus.read_sel1 = '0; bus.read_sel2 = '0; bus.write_sel = '0;
        bus.write_en = 0; bus.write_data = '0; bus.sp_push = 0; bus.sp_pop = 0;
        bus.ctx_save = 0; bus.ctx_restore = 0; bus.flag_clr = 0;
    endtask

    // Check pre-edge view, clock once, advance model; returns at the next falling edge
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int sel, input logic [15:0] d);
        bus.write_en = 1; bus.write_sel = 4'(sel); bus.write_data = d;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all();
        check_val("reset_sp", 32'(bus.sp_out), 32'h0FFF);
        @(negedge clk);
        rst_n = 1;

        // Basic GPR and SP writes
        wr(3, 16'hBEEF);
        wr(NG, 16'hF123);
        bus.read_sel1 = 4'(NG);
        #1;
        check_val("r3_flat", 32'(bus.regs_out_flat[63:48]), 32'hBEEF);
        check_val("rd_sp", 32'(bus.read_data1), 32'h0123);
        check_val("sp_val", 32'(bus.sp_out), 32'h0123);

        // Same-cycle forwarding versus pre-edge read
        bus.read_sel1 = 4'd5; bus.write_en = 1; bus.write_sel = 4'd5; bus.write_data = 16'h1234;
        #1;
        check_val("byp_same", 32'(bus.read_data1), 32'h1234);
        check_val("nobyp_same", 32'(bus0.read_data1), 32'h0000);
        tick();
        bus.read_sel1 = 4'd5;
        #1 check_val("nobyp_next", 32'(bus0.read_data1), 32'h1234);

        // Stack bounds
        rst_n = 0; #1; model_reset(); @(negedge clk); rst_n = 1;
        bus.sp_pop = 1; tick();
        check_val("unf_set", 32'(bus.stk_unf), 32'h1);
        check_val("unf_sp", 32'(bus.sp_out), 32'hFFF);
        wr(NG, 16'h0801);
        bus.sp_push = 1; tick();
        bus.sp_push = 1; tick();
        check_val("ovf_sp", 32'(bus.sp_out), 32'h800);
        check_val("ovf_set", 32'(bus.stk_ovf), 32'h1);
        bus.flag_clr = 1; tick();
        check_val("clr_ovf", 32'(bus.stk_ovf), 32'h0);
        check_val("clr_unf", 32'(bus.stk_unf), 32'h0);

        // Context save / restore with a same-cycle write winning on R2
        for (int j = 0; j < NG; j++) wr(j, 16'(j + 1));
        wr(NG + 1, 16'h00AA);
        bus.ctx_save = 1; tick();
        for (int j = 0; j < NG; j++) wr(j, 16'h0);
        wr(NG + 1, 16'h0);
        bus.ctx_restore = 1; bus.write_en = 1; bus.write_sel = 4'd2; bus.write_data = 16'h0055;
        tick();
        check_val("rst_r2", 32'(bus.regs_out_flat[47:32]), 32'h55);
        check_val("rst_r7", 32'(bus.regs_out_flat[127:112]), 32'h8);
        check_val("rst_isr", 32'(bus.isr_out), 32'h0AA);
        check_val("rst_sv", 32'(bus.shadow_valid), 32'h0);

        // Nesting errors
        bus.ctx_save = 1; tick();
        wr(0, 16'h7777);
        bus.ctx_save = 1; tick();
        check_val("nest_save", 32'(bus.nest_err), 32'h1);
        bus.ctx_restore = 1; tick();
        check_val("shadow_kept", 32'(bus.regs_out_flat[15:0]), 32'h1);
        bus.flag_clr = 1; tick();
        bus.ctx_restore = 1; tick();
        check_val("nest_restore", 32'(bus.nest_err), 32'h1);

        // Asynchronous reset between edges after a push and a save
        bus.sp_push = 1; bus.ctx_save = 1; tick();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_val("arst_sp", 32'(bus.sp_out), 32'hFFF);
        check_val("arst_sv", 32'(bus.shadow_valid), 32'h0);
        check_val("arst_flags", 32'({bus.stk_ovf, bus.stk_unf, bus.nest_err}), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bus.read_sel1   = 4'($urandom_range(0, 15));
            bus.read_sel2   = 4'($urandom_range(0, 15));
            bus.write_sel   = ($urandom_range(0, 3) == 0) ? bus.read_sel1 : 4'($urandom_range(0, 15));
            bus.write_en    = 1'($urandom_range(0, 1));
            bus.write_data  = 16'($urandom);
            bus.sp_push     = ($urandom_range(0, 2) == 0);
            bus.sp_pop      = ($urandom_range(0, 2) == 0);
            bus.ctx_save    = ($urandom_range(0, 7) == 0);
            bus.ctx_restore = ($urandom_range(0, 7) == 0);
            bus.flag_clr    = ($urandom_range(0, 9) == 0);
            tick();
        end
        #1 check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
